ccff_chain_loader: RTL
======================

CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the bitstream word width in bits (legal range 1..32).
REQ-002 The block SHALL have parameter CHAIN_LEN, default 64, giving the number of configuration flip-flops in the ccff chain (legal range 1..65535).
REQ-003 The block SHALL have port prog_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port prog_reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: one-cycle request to begin a chain load.
REQ-006 The block SHALL have port abort, input, 1 bit: cancels a load in progress.
REQ-007 The block SHALL have port s_data, input, DATA_W bits: bitstream word, shifted LSB first.
REQ-008 The block SHALL have port s_valid, input, 1 bit: s_data is valid.
REQ-009 The block SHALL have port s_ready, output, 1 bit: the block accepts s_data this cycle.
REQ-010 The block SHALL have port ccff_head, output, 1 bit: serial data into the chain head.
REQ-011 The block SHALL have port ccff_shift_en, output, 1 bit: chain shifts on this prog_clk edge.
REQ-012 The block SHALL have port busy, output, 1 bit: a load is in progress.
REQ-013 The block SHALL have port cfg_done, output, 1 bit: the chain holds a complete CHAIN_LEN-bit load.
REQ-014 The block SHALL have port bit_cnt, output, 16 bits: number of bits shifted in the current load.

Function
REQ-015 The block SHALL implement the states IDLE, LOAD, SHIFT and DONE.
REQ-016 In IDLE or DONE, start=1 SHALL cause a transition to LOAD, clear bit_cnt to 0 and deassert cfg_done on the next edge.
REQ-017 start SHALL be ignored while in LOAD or SHIFT.
REQ-018 In LOAD, s_ready SHALL be 1; in all other states s_ready SHALL be 0.
REQ-019 A transfer SHALL occur only on an edge where s_valid=1 and s_ready=1; on that edge the word is latched into a DATA_W-bit shift register and the state becomes SHIFT.
REQ-020 In SHIFT, on every cycle ccff_shift_en SHALL be 1 and ccff_head SHALL equal the current shift-register LSB.
REQ-021 In SHIFT, on each edge the shift register SHALL shift right by one and bit_cnt SHALL increment by 1.
REQ-022 ccff_head and ccff_shift_en SHALL be registered outputs; the first bit of an accepted word is presented in the cycle immediately after the accepting edge.
REQ-023 The block SHALL leave SHIFT after DATA_W bits of the current word, or earlier on the edge where bit_cnt reaches CHAIN_LEN.
REQ-024 On leaving SHIFT, the next state SHALL be DONE if bit_cnt has reached CHAIN_LEN, otherwise LOAD.
REQ-025 Unused high bits of the final word SHALL be discarded and never driven onto ccff_head.
REQ-026 Outside SHIFT, ccff_shift_en SHALL be 0 and ccff_head SHALL be 0.
REQ-027 Throughput SHALL be one word per DATA_W+1 cycles while s_valid is held high; s_valid=0 in LOAD stalls the block indefinitely with no shift.
REQ-028 In DONE, cfg_done SHALL be 1 and bit_cnt SHALL hold CHAIN_LEN until the next start.
REQ-029 busy SHALL be 1 exactly in LOAD and SHIFT.
REQ-030 abort=1 in LOAD or SHIFT SHALL force IDLE on the next edge, with ccff_shift_en=0, cfg_done=0 and bit_cnt held at its value.
REQ-031 abort SHALL have priority over s_valid and over SHIFT completion on the same edge; abort in IDLE or DONE SHALL have no effect.
REQ-032 bit_cnt SHALL never exceed CHAIN_LEN and SHALL never wrap.

Reset
REQ-033 While prog_reset_n=0, the block SHALL be in IDLE with s_ready=0, ccff_head=0, ccff_shift_en=0, busy=0, cfg_done=0, bit_cnt=0 and the shift register at 0.
REQ-034 Reset assertion SHALL take effect asynchronously, including mid-SHIFT, with no further ccff_shift_en pulse.
REQ-035 Deassertion SHALL be sampled synchronously; the first state change is possible on the first prog_clk edge after release.

Verification
REQ-036 Bench: DATA_W=8, CHAIN_LEN=16, start, words 0xA5 then 0x3C with s_valid held high -> ccff_head sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0, each bit with ccff_shift_en=1; cfg_done=1 eighteen cycles after LOAD entry; bit_cnt=16.
REQ-037 Bench: CHAIN_LEN=12, DATA_W=8, words 0xFF and 0x0F -> exactly 12 shift pulses; the final 4 bits are 1,1,1,1; upper nibble is dropped; DONE is reached.
REQ-038 Bench: s_valid low for 5 cycles in LOAD -> s_ready=1 throughout, zero shift pulses, bit_cnt unchanged; the load resumes on s_valid.
REQ-039 Bench: abort after bit 3 of word 0 -> IDLE next edge, ccff_shift_en=0, cfg_done=0, bit_cnt=3; a subsequent start reloads from bit_cnt=0.
REQ-040 Bench: prog_reset_n low mid-SHIFT -> all outputs 0 immediately, asynchronously to prog_clk; start after release begins a clean load.
REQ-041 Bench: start pulsed during SHIFT and again in DONE -> the first is ignored; the second clears cfg_done and enters LOAD.

Source files
------------

// File: rtl/ccff_chain_loader.sv
// Loads a configuration flip-flop chain from a stream of DATA_W-bit words, LSB first.
// Handshake-paced per word and stops exactly at CHAIN_LEN bits, dropping any leftover word bits.
module ccff_chain_loader #(
    parameter int DATA_W    = 8,
    parameter int CHAIN_LEN = 64
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    output logic              busy,
    output logic              cfg_done,
    output logic [15:0]       bit_cnt
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    localparam int              IDX_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
    localparam logic [15:0]      CHAIN_END = 16'(CHAIN_LEN);

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [IDX_W-1:0]  bit_idx;
    logic [DATA_W-1:0] shreg_next;
    logic [15:0]       cnt_next;

    assign shreg_next = shreg >> 1;
    assign cnt_next   = bit_cnt + 16'd1;
    assign s_ready    = (state == LOAD);
    assign busy       = (state == LOAD) || (state == SHIFT);

    // ccff_head/ccff_shift_en are computed from next-state values so they
    // always describe the bit that the chain captures on the coming edge.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state         <= IDLE;
            shreg         <= '0;
            bit_idx       <= '0;
            bit_cnt       <= '0;
            ccff_head     <= 1'b0;
            ccff_shift_en <= 1'b0;
            cfg_done      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every branch reads the pre-edge state.
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= LOAD;
                        bit_cnt  <= '0;
                        cfg_done <= 1'b0;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (s_valid) begin
                        state         <= SHIFT;
                        shreg         <= s_data;
                        bit_idx       <= '0;
                        ccff_head     <= s_data[0];
                        ccff_shift_en <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        state         <= IDLE;
                        ccff_head     <= 1'b0;
                        ccff_shift_en <= 1'b0;
                        cfg_done      <= 1'b0;
                    end else begin
                        shreg   <= shreg_next;
                        bit_cnt <= cnt_next;
                        bit_idx <= bit_idx + IDX_W'(1);
                        if (cnt_next == CHAIN_END) begin
                            // Chain full: remaining word bits are never presented.
                            state         <= DONE;
                            cfg_done      <= 1'b1;
                            ccff_head     <= 1'b0;
                            ccff_shift_en <= 1'b0;
                        end else if (bit_idx == LAST_IDX) begin
                            state         <= LOAD;
                            ccff_head     <= 1'b0;
                            ccff_shift_en <= 1'b0;
                        end else begin
                            ccff_head     <= shreg_next[0];
                            ccff_shift_en <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
